// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM encoding and
// access-size/alignment helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  function automatic logic is_store(input lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic lsu_size_e access_size(input lsu_op_e op);
    lsu_size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input lsu_op_e op, input logic [1:0] off);
    logic bad;
    case (access_size(op))
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel from the datapath and the Data_Memory port,
// each as its own interface so the unit can be slave on one, master on the other.
interface lsu_req_if;
  logic        LSU_Req_Valid;
  logic        LSU_Req_Ready;
  logic [2:0]  LSU_Req_Op;
  logic [31:0] LSU_Req_Address;
  logic [31:0] LSU_Req_Store_Data;
  logic        LSU_Resp_Valid;
  logic [31:0] LSU_Resp_Data;
  logic        LSU_Resp_Error;

  modport master (
    output LSU_Req_Valid, LSU_Req_Op, LSU_Req_Address, LSU_Req_Store_Data,
    input  LSU_Req_Ready, LSU_Resp_Valid, LSU_Resp_Data, LSU_Resp_Error
  );

  modport slave (
    input  LSU_Req_Valid, LSU_Req_Op, LSU_Req_Address, LSU_Req_Store_Data,
    output LSU_Req_Ready, LSU_Resp_Valid, LSU_Resp_Data, LSU_Resp_Error
  );
endinterface

interface lsu_dm_if #(parameter int DM_ADDR_WIDTH = 32);
  logic [DM_ADDR_WIDTH-1:0] DM_Input_Address;
  logic [31:0]              DM_Data_To_Write;
  logic                     DM_Write_Enable_Flag;
  logic [31:0]              DM_Output_Data;

  modport master (
    output DM_Input_Address, DM_Data_To_Write, DM_Write_Enable_Flag,
    input  DM_Output_Data
  );

  modport slave (
    input  DM_Input_Address, DM_Data_To_Write, DM_Write_Enable_Flag,
    output DM_Output_Data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// sub-word store merge into the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel      = mem_word_i[7:0];
    half_sel      = off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    sext          = (op_i == OP_LB) || (op_i == OP_LH);
    load_data_o   = mem_word_i;
    merged_word_o = mem_word_i;

    case (off_i)
      2'd1:    byte_sel = mem_word_i[15:8];
      2'd2:    byte_sel = mem_word_i[23:16];
      2'd3:    byte_sel = mem_word_i[31:24];
      default: byte_sel = mem_word_i[7:0];
    endcase

    case (access_size(op_i))
      SZ_BYTE: load_data_o = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{sext & half_sel[15]}}, half_sel};
      default: load_data_o = mem_word_i;
    endcase

    // Only the addressed lane changes; the rest keeps the READ word.
    case (access_size(op_i))
      SZ_BYTE: begin
        case (off_i)
          2'd1:    merged_word_o[15:8]  = store_data_i[7:0];
          2'd2:    merged_word_o[23:16] = store_data_i[7:0];
          2'd3:    merged_word_o[31:24] = store_data_i[7:0];
          default: merged_word_o[7:0]   = store_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off_i[1]) merged_word_o[31:16] = store_data_i[15:0];
        else          merged_word_o[15:0]  = store_data_i[15:0];
      end
      default: merged_word_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for Data_Memory with sub-word
// read-modify-write stores.
//
// state | meaning
// IDLE  | ready; capture request on valid
// READ  | memory word registered (loads, SB/SH)
// WRITE | write strobe for one cycle
// DONE  | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDR_WIDTH = 32
) (
  input logic        CLK,
  input logic        RST_N,
  lsu_req_if.slave   req,
  lsu_dm_if.master   dm
);

  lsu_state_e               state_q, state_d;
  lsu_op_e                  op_q, op_d;
  logic [1:0]               off_q, off_d;
  logic [DM_ADDR_WIDTH-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  lsu_op_e     req_op;

  logic        ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        we;
  logic [31:0] wr_word;

  assign req_op = lsu_op_e'(req.LSU_Req_Op);

  lsu_lane_align u_lane_align (
    .op_i          (op_q),
    .off_i         (off_q),
    .mem_word_i    (rdata_q),
    .store_data_i  (wdata_q),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LB;
      off_q     <= '0;
      dm_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      off_q     <= off_d;
      dm_addr_q <= dm_addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    dm_addr_d  = dm_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ready      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    we         = 1'b0;
    wr_word    = '0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req.LSU_Req_Valid) begin
          op_d      = req_op;
          off_d     = req.LSU_Req_Address[1:0];
          dm_addr_d = DM_ADDR_WIDTH'(req.LSU_Req_Address >> 2);
          wdata_d   = req.LSU_Req_Store_Data;
          rdata_d   = '0;
          err_d     = misaligned(req_op, req.LSU_Req_Address[1:0]);
          // Misaligned requests skip memory entirely.
          if (misaligned(req_op, req.LSU_Req_Address[1:0])) state_d = ST_DONE;
          else if (req_op == OP_SW)                         state_d = ST_WRITE;
          else                                              state_d = ST_READ;
        end
      end
      ST_READ: begin
        rdata_d = dm.DM_Output_Data;
        state_d = is_store(op_q) ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        we      = 1'b1;
        wr_word = merged_word;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_data  = (err_q || is_store(op_q)) ? 32'd0 : load_data;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decodes straight from the async-reset state, so reset kills it at once.
  assign req.LSU_Req_Ready        = ready;
  assign req.LSU_Resp_Valid       = resp_valid;
  assign req.LSU_Resp_Data        = resp_data;
  assign req.LSU_Resp_Error       = resp_err;
  assign dm.DM_Input_Address      = dm_addr_q;
  assign dm.DM_Data_To_Write      = wr_word;
  assign dm.DM_Write_Enable_Flag  = we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word behavioural Data_Memory.
module tb_load_store_unit;

  logic clk;
  logic rst_n;

  lsu_req_if req_if ();
  lsu_dm_if #(.DM_ADDR_WIDTH(32)) dm_if ();

  load_store_unit #(.DM_ADDR_WIDTH(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .req   (req_if.slave),
    .dm    (dm_if.master)
  );

  logic [31:0] mem [16];
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_if.DM_Output_Data = mem[dm_if.DM_Input_Address[3:0]];

  always @(posedge clk)
    if (dm_if.DM_Write_Enable_Flag) mem[dm_if.DM_Input_Address[3:0]] <= dm_if.DM_Data_To_Write;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input int exp_lat, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_we, input logic [31:0] exp_wdata);
    int resp_cyc;
    int we_cyc;
    int we_cnt;
    logic [31:0] got_data;
    logic [31:0] got_wd;
    logic        got_err;
    resp_cyc = -1; we_cyc = 0; we_cnt = 0;
    got_data = '0; got_wd = '0; got_err = 1'b0;
    @(negedge clk);
    check_val({tag, "_ready"}, 32'(req_if.LSU_Req_Ready), 32'd1);
    req_if.LSU_Req_Valid      = 1'b1;
    req_if.LSU_Req_Op         = op;
    req_if.LSU_Req_Address    = addr;
    req_if.LSU_Req_Store_Data = sdata;
    @(posedge clk);
    #1;
    req_if.LSU_Req_Valid      = 1'b0;
    req_if.LSU_Req_Address    = 32'hFFFF_FFFF;
    req_if.LSU_Req_Store_Data = 32'h5A5A_5A5A;
    for (int c = 1; c <= 10 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) check_val({tag, "_addr"}, dm_if.DM_Input_Address, addr >> 2);
      if (dm_if.DM_Write_Enable_Flag) begin
        if (we_cyc == 0) begin
          we_cyc = c;
          got_wd = dm_if.DM_Data_To_Write;
        end
        we_cnt++;
      end
      if (req_if.LSU_Resp_Valid) begin
        resp_cyc = c;
        got_data = req_if.LSU_Resp_Data;
        got_err  = req_if.LSU_Resp_Error;
      end
    end
    check_val({tag, "_lat"},   32'(resp_cyc), 32'(exp_lat));
    check_val({tag, "_data"},  got_data, exp_data);
    check_val({tag, "_err"},   32'(got_err), 32'(exp_err));
    check_val({tag, "_wecyc"}, 32'(we_cyc), 32'(exp_we));
    check_val({tag, "_wecnt"}, 32'(we_cnt), (exp_we != 0) ? 32'd1 : 32'd0);
    if (exp_we != 0) check_val({tag, "_wdata"}, got_wd, exp_wdata);
  endtask

  task automatic quiet_after_reset(input string tag);
    int busy;
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (req_if.LSU_Resp_Valid || dm_if.DM_Write_Enable_Flag || !req_if.LSU_Req_Ready) busy++;
    end
    check_val({tag, "_quiet"}, 32'(busy), 32'd0);
    check_val({tag, "_mem0"}, mem[0], 32'h1234BEEF);
  endtask

  task automatic accept(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    @(negedge clk);
    req_if.LSU_Req_Valid      = 1'b1;
    req_if.LSU_Req_Op         = op;
    req_if.LSU_Req_Address    = addr;
    req_if.LSU_Req_Store_Data = sdata;
    @(posedge clk);
    #1;
    req_if.LSU_Req_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] rdy_mask;
    logic [6:0] rsp_mask;
    logic [31:0] b2b_data;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    mem[1] <= 32'h000080FF;
    mem[2] <= 32'h8899AABB;
    mem[3] <= 32'h11223344;
    rst_n = 1'b0;
    req_if.LSU_Req_Valid      = 1'b0;
    req_if.LSU_Req_Op         = 3'd0;
    req_if.LSU_Req_Address    = 32'd0;
    req_if.LSU_Req_Store_Data = 32'd0;
    repeat (3) @(negedge clk);

    check_val("rst_ready", 32'(req_if.LSU_Req_Ready), 32'd1);
    check_val("rst_rvalid", 32'(req_if.LSU_Resp_Valid), 32'd0);
    check_val("rst_rerr", 32'(req_if.LSU_Resp_Error), 32'd0);
    check_val("rst_rdata", req_if.LSU_Resp_Data, 32'd0);
    check_val("rst_addr", dm_if.DM_Input_Address, 32'd0);
    check_val("rst_wdata", dm_if.DM_Data_To_Write, 32'd0);
    check_val("rst_we", 32'(dm_if.DM_Write_Enable_Flag), 32'd0);
    rst_n = 1'b1;

    //        tag      op    addr   sdata          lat data           err we wdata
    do_req("lw8",   3'd2, 32'h8, 32'h0,         2, 32'h8899AABB, 0, 0, 32'h0);
    do_req("lb5",   3'd0, 32'h5, 32'h0,         2, 32'hFFFFFF80, 0, 0, 32'h0);
    do_req("lbu5",  3'd3, 32'h5, 32'h0,         2, 32'h00000080, 0, 0, 32'h0);
    do_req("lh4",   3'd1, 32'h4, 32'h0,         2, 32'hFFFF80FF, 0, 0, 32'h0);
    do_req("lhuA",  3'd4, 32'hA, 32'h0,         2, 32'h00008899, 0, 0, 32'h0);
    do_req("lhA",   3'd1, 32'hA, 32'h0,         2, 32'hFFFF8899, 0, 0, 32'h0);
    do_req("sbE",   3'd5, 32'hE, 32'hFFFFFFAB,  3, 32'h0,        0, 2, 32'h11AB3344);
    do_req("lwC",   3'd2, 32'hC, 32'h0,         2, 32'h11AB3344, 0, 0, 32'h0);
    do_req("sw0",   3'd7, 32'h0, 32'hDEADBEEF,  2, 32'h0,        0, 1, 32'hDEADBEEF);
    do_req("sh2",   3'd6, 32'h2, 32'hFFFF1234,  3, 32'h0,        0, 2, 32'h1234BEEF);
    check_val("mem0_after_sh", mem[0], 32'h1234BEEF);
    do_req("lw6",   3'd2, 32'h6, 32'h0,         1, 32'h0,        1, 0, 32'h0);
    do_req("sh3",   3'd6, 32'h3, 32'h0000CAFE,  1, 32'h0,        1, 0, 32'h0);
    check_val("mem0_after_sh3", mem[0], 32'h1234BEEF);

    // Reset during the READ cycle of an SB.
    accept(3'd5, 32'h0, 32'h00000077);
    @(negedge clk);
    check_val("rstr_busy", 32'(req_if.LSU_Req_Ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("rstr_ready", 32'(req_if.LSU_Req_Ready), 32'd1);
    check_val("rstr_we", 32'(dm_if.DM_Write_Enable_Flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_after_reset("rstr");

    // Reset during the WRITE cycle of an SH: strobe must drop without a clock.
    accept(3'd6, 32'h0, 32'h00005555);
    @(negedge clk);
    @(negedge clk);
    check_val("rstw_we_on", 32'(dm_if.DM_Write_Enable_Flag), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstw_we_off", 32'(dm_if.DM_Write_Enable_Flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_after_reset("rstw");

    // Back-to-back LW with valid held: accepts at cycles 0 and 3.
    rdy_mask = '0;
    rsp_mask = '0;
    b2b_data = '0;
    @(negedge clk);
    req_if.LSU_Req_Valid   = 1'b1;
    req_if.LSU_Req_Op      = 3'd2;
    req_if.LSU_Req_Address = 32'h8;
    rdy_mask[0] = req_if.LSU_Req_Ready;
    rsp_mask[0] = req_if.LSU_Resp_Valid;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdy_mask[c] = req_if.LSU_Req_Ready;
      rsp_mask[c] = req_if.LSU_Resp_Valid;
      if (c == 5) b2b_data = req_if.LSU_Resp_Data;
    end
    req_if.LSU_Req_Valid = 1'b0;
    check_val("b2b_ready", 32'(rdy_mask), 32'b1001001);
    check_val("b2b_resp", 32'(rsp_mask), 32'b0100100);
    check_val("b2b_data2", b2b_data, 32'h8899AABB);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential initiator for `Data_Memory` that sits between the MIPS datapath and the data memory port. It accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, write-data and write-enable pins. It performs byte and halfword accesses, using read-modify-write for sub-word stores, and returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- `DM_ADDR_WIDTH`, default 32: width of the word address driven to `Data_Memory`.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `LSU_Req_Valid` in 1: request present.
- `LSU_Req_Ready` out 1: unit can accept a request this cycle.
- `LSU_Req_Op` in 3: operation code, 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- `LSU_Req_Address` in 32: byte address.
- `LSU_Req_Store_Data` in 32: store data, right-aligned for SB/SH.
- `LSU_Resp_Valid` out 1: one-cycle completion pulse.
- `LSU_Resp_Data` out 32: extended load result; 0 for stores.
- `LSU_Resp_Error` out 1: misaligned access, qualified by `LSU_Resp_Valid`.
- `DM_Input_Address` out DM_ADDR_WIDTH: word address, byte address >> 2.
- `DM_Data_To_Write` out 32: full word to write.
- `DM_Write_Enable_Flag` out 1: memory write strobe.
- `DM_Output_Data` in 32: combinational read data from memory.

## Operation
- FSM states are IDLE, READ, WRITE and DONE.
- **IDLE:**
  - `LSU_Req_Ready` = 1.
  - On `LSU_Req_Valid`, op, address and store data are captured into registers. Request inputs are don't-care afterwards.
- **Next state from IDLE:**
  - Misaligned request → DONE with error set. A halfword op is misaligned when addr[0]=1; a word op when addr[1:0]≠0.
  - Loads, SB and SH → READ.
  - SW → WRITE.
- **READ:** drives the captured word address and registers `DM_Output_Data`.
  - Load → DONE.
  - SB/SH → WRITE.
- **WRITE:** asserts `DM_Write_Enable_Flag` for exactly this cycle and drives `DM_Data_To_Write`.
  - SW writes the captured data.
  - SB/SH write the READ word with the addressed lane replaced.
  - Next state → DONE.
- **DONE:** `LSU_Resp_Valid` = 1 for one cycle, then → IDLE. The response is never back-pressured.
- **Lane rules (little-endian):**
  - Byte offset k occupies bits [8k+7:8k].
  - Halfword offset 0 occupies [15:0]; offset 2 occupies [31:16].
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
- A misaligned request issues no memory access (WE never asserted) and returns `LSU_Resp_Data` = 0.
- `DM_Input_Address` holds the last captured word address in all states. It is 0 after reset.

## Timing
- Cycle 0 is the accept edge (IDLE with valid).
- **Latency to the `LSU_Resp_Valid` cycle:**
  - Loads: READ in cycle 1, DONE in cycle 2.
  - SW: WRITE in cycle 1, DONE in cycle 2.
  - SB/SH: READ in cycle 1, WRITE in cycle 2, DONE in cycle 3.
  - Misaligned: DONE in cycle 1.
- Throughput: the next accept happens at the earliest in the cycle after DONE (IDLE). `LSU_Req_Ready` is 0 in READ, WRITE and DONE.
- Memory write takes effect at the rising edge that ends the WRITE cycle.
- **Reset values:**
  - State = IDLE.
  - `LSU_Req_Ready` = 1.
  - `LSU_Resp_Valid` = 0, `LSU_Resp_Error` = 0, `LSU_Resp_Data` = 0.
  - `DM_Input_Address` = 0, `DM_Data_To_Write` = 0, `DM_Write_Enable_Flag` = 0.
  - All capture registers = 0.
- Reset mid-operation:
  - `DM_Write_Enable_Flag` drops immediately (asynchronously), so no partial RMW write occurs.
  - The pending request is discarded and no response is issued.
- A request held valid during non-IDLE states is not accepted until IDLE.

## Structure
- Shared package `lsu_pkg` contains:
  - The op-code constants (OP_LB … OP_SW).
  - The FSM state encoding.
  - The helper functions `is_store(op)`, `access_size(op)` and `misaligned(op, addr[1:0])`.
- One natural sub-module is `lsu_lane_align`. It is combinational and performs load extraction/extension plus store lane merge. It takes op, byte offset, memory word and store data, and produces load result and merged word.
- The FSM and capture registers live in `load_store_unit`.

## Test plan
- **LW:** memory word 2 = 0x8899AABB; LW at 0x8 → response in cycle 2, data 0x8899AABB, error 0, WE never high.
- **LB/LBU:** memory word 1 = 0x000080FF.
  - LB at 0x5 → 0xFFFFFF80.
  - LBU at 0x5 → 0x00000080.
  - LH at 0x4 → 0xFFFF80FF.
- **SB RMW:** memory word 3 = 0x11223344; SB 0xAB at 0xE.
  - Expected: WE high in cycle 2 only, `DM_Data_To_Write` = 0x11AB3344, response cycle 3.
  - Follow-up: LW 0xC returns 0x11AB3344.
- **SW then SH:**
  - SW 0xDEADBEEF at 0x0.
  - SH 0x1234 at 0x2 → word 0 = 0x1234BEEF.
- **Misaligned:**
  - LW at 0x6 → response cycle 1, error 1, data 0, WE stays 0.
  - SH at 0x3 → same response; memory unchanged.
- **Reset / back-to-back:**
  - Assert `RST_N` low during the READ cycle of SB at 0x0 → no write, no `LSU_Resp_Valid`, `LSU_Req_Ready` = 1 after release.
  - Two back-to-back requests with valid held high → second accepted exactly in the cycle after the first DONE.
